// File: rtl/ttc_frame_tx.sv
// rtl/ttc_frame_tx.sv - serial TTC encoder: triggers and command frames as 4-bit symbols, one per BX, MSB first
//
// Purpose:
//   Four 160 MHz cycles make one bunch crossing (BX). One 4-bit symbol is sent per BX.
//   Symbols are IDLE 0000, TRIG 1111, START 1001, D0 1000 and D1 1100.
//   Pending triggers take priority over command-frame symbols. A pre-empted frame resumes
//   at the next free BX without skipping or repeating any symbol.
//   Optional build macro TTC_TX_PARITY_EN: appends an even-parity symbol to every frame.
//
// Ports:
//   i_clk160        160 MHz clock
//   i_rst           synchronous active-high reset
//   i_bx_align      pulse: the next cycle becomes BX phase 0
//   i_trigger       trigger request; each high cycle counts as one trigger
//   i_cmd_valid     command word offered
//   i_cmd_data      command payload
//   o_cmd_ready     the block accepts i_cmd_data this cycle
//   o_ser_out       serial symbol stream
//   o_sym_strobe    high while o_ser_out carries bit 3 of a symbol
//   o_busy          a command frame is held or in progress
//   o_trig_dropped  1-cycle pulse: a trigger was lost because the pending counter was saturated

module ttc_frame_tx #(
    parameter int CMD_WIDTH   = 16,
    parameter int MAX_PENDING = 3
) (
    input  logic                 i_clk160,
    input  logic                 i_rst,
    input  logic                 i_bx_align,
    input  logic                 i_trigger,
    input  logic                 i_cmd_valid,
    input  logic [CMD_WIDTH-1:0] i_cmd_data,
    output logic                 o_cmd_ready,
    output logic                 o_ser_out,
    output logic                 o_sym_strobe,
    output logic                 o_busy,
    output logic                 o_trig_dropped
);

    localparam int            BW       = (CMD_WIDTH > 1) ? $clog2(CMD_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_TOP  = BW'(CMD_WIDTH - 1);
    localparam logic [2:0]    PEND_MAX = 3'(MAX_PENDING);

    localparam logic [3:0] SYM_IDLE  = 4'b0000;
    localparam logic [3:0] SYM_TRIG  = 4'b1111;
    localparam logic [3:0] SYM_START = 4'b1001;
    localparam logic [3:0] SYM_D0    = 4'b1000;
    localparam logic [3:0] SYM_D1    = 4'b1100;

    // The state names the frame symbol most recently put on the line.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2
`ifdef TTC_TX_PARITY_EN
        , S_PAR = 2'd3
`endif
    } state_t;

    logic [1:0]           r_phase;
    logic [3:0]           r_sym;
    logic                 r_ser;
    logic                 r_strobe;
    logic [2:0]           r_pend;
    logic                 r_drop;
    state_t               r_state;
    logic [BW-1:0]        r_bit;
    logic                 r_held;
    logic [CMD_WIDTH-1:0] r_cmd;
    // Snapshot taken before the last frame symbol was loaded, so that a symbol
    // truncated by bx_align can be sent again.
    logic                 r_last_frame;
    state_t               r_prev_state;
    logic [BW-1:0]        r_prev_bit;
    logic                 r_prev_held;

    logic          w_boundary;
    logic          w_rollback;
    logic          w_accept;
    logic          w_avail;
    logic          w_trig_sel;
    logic          w_commit;
    logic          w_dec;
    logic          w_drop;
    logic          w_frame_load;
    logic          w_start_taken;
    logic [3:0]    w_frame_sym;
    logic [3:0]    w_sym_nx;
    logic          w_ser_nx;
    logic [1:0]    w_phase_nx;
    logic [2:0]    w_pend_nx;
    state_t        w_state;
    state_t        w_fstate_nx;
    state_t        w_state_nx;
    logic [BW-1:0] w_bit;
    logic [BW-1:0] w_bit_m1;
    logic [BW-1:0] w_fbit_nx;
    logic [BW-1:0] w_bit_nx;
    logic          w_held;
    logic          w_held_nx;
    logic          w_last_frame_nx;

    assign o_cmd_ready    = ~i_rst & (r_state == S_IDLE) & ~r_held;
    assign o_busy         = r_held | (r_state != S_IDLE);
    assign o_ser_out      = r_ser;
    assign o_sym_strobe   = r_strobe;
    assign o_trig_dropped = r_drop;

    function automatic logic [3:0] data_sym(input logic b);
        return b ? SYM_D1 : SYM_D0;
    endfunction

    always_comb begin
        w_boundary = (r_phase == 2'd3) | i_bx_align;
        // A bx_align before phase 3 cuts the current symbol short. If that symbol
        // belonged to the frame, the frame position is rolled back.
        w_rollback = i_bx_align & (r_phase != 2'd3) & r_last_frame;
        w_state    = w_rollback ? r_prev_state : r_state;
        w_bit      = w_rollback ? r_prev_bit   : r_bit;
        w_held     = w_rollback ? r_prev_held  : r_held;
        w_bit_m1   = w_bit - 1'b1;
        w_accept   = i_cmd_valid & o_cmd_ready;
        // A word accepted in the decision cycle may start at this same boundary.
        w_avail    = w_held | w_accept;
        w_trig_sel = (r_pend != 3'd0) | i_trigger;
        w_commit   = w_boundary & ~w_trig_sel;

        // Frame symbol to send if this boundary goes to the frame.
        w_frame_sym   = SYM_IDLE;
        w_frame_load  = 1'b0;
        w_start_taken = 1'b0;
        w_fstate_nx   = w_state;
        w_fbit_nx     = w_bit;
        case (w_state)
            S_START: begin
                w_frame_sym  = data_sym(r_cmd[CMD_WIDTH-1]);
                w_frame_load = 1'b1;
                w_fstate_nx  = S_DATA;
                w_fbit_nx    = BIT_TOP;
            end
            S_DATA: begin
                if (w_bit != '0) begin
                    w_frame_sym  = data_sym(r_cmd[w_bit_m1]);
                    w_frame_load = 1'b1;
                    w_fbit_nx    = w_bit_m1;
                end else begin
`ifdef TTC_TX_PARITY_EN
                    w_frame_sym  = data_sym(^r_cmd);
                    w_frame_load = 1'b1;
                    w_fstate_nx  = S_PAR;
`else
                    w_fstate_nx  = S_IDLE;
`endif
                end
            end
`ifdef TTC_TX_PARITY_EN
            S_PAR: w_fstate_nx = S_IDLE;
`endif
            default: ;
        endcase
        if ((w_fstate_nx == S_IDLE) && w_avail) begin
            w_frame_sym   = SYM_START;
            w_frame_load  = 1'b1;
            w_start_taken = 1'b1;
            w_fstate_nx   = S_START;
        end

        // The pending counter stays put when a trigger arrives and a TRIG is sent in the same cycle.
        w_dec     = w_boundary & w_trig_sel;
        w_drop    = i_trigger & ~w_dec & (r_pend == PEND_MAX);
        w_pend_nx = r_pend;
        if (i_trigger & ~w_dec & ~w_drop) begin
            w_pend_nx = r_pend + 3'd1;
        end else if (~i_trigger & w_dec) begin
            w_pend_nx = r_pend - 3'd1;
        end

        w_state_nx      = w_commit ? w_fstate_nx : w_state;
        w_bit_nx        = w_commit ? w_fbit_nx   : w_bit;
        w_held_nx       = (w_commit & w_start_taken) ? 1'b0 : w_avail;
        w_last_frame_nx = w_boundary ? (w_commit & w_frame_load) : r_last_frame;

        w_sym_nx = w_trig_sel ? SYM_TRIG : w_frame_sym;
        if (w_boundary) begin
            w_phase_nx = 2'd0;
            w_ser_nx   = w_sym_nx[3];
        end else begin
            w_phase_nx = r_phase + 2'd1;
            case (r_phase)
                2'd0:    w_ser_nx = r_sym[2];
                2'd1:    w_ser_nx = r_sym[1];
                default: w_ser_nx = r_sym[0];
            endcase
        end
    end

    always_ff @(posedge i_clk160) begin
        if (i_rst) begin
            r_phase      <= 2'd0;
            r_sym        <= SYM_IDLE;
            r_ser        <= 1'b0;
            r_strobe     <= 1'b0;
            r_pend       <= 3'd0;
            r_drop       <= 1'b0;
            r_state      <= S_IDLE;
            r_bit        <= '0;
            r_held       <= 1'b0;
            r_cmd        <= '0;
            r_last_frame <= 1'b0;
            r_prev_state <= S_IDLE;
            r_prev_bit   <= '0;
            r_prev_held  <= 1'b0;
        end else begin
            r_phase      <= w_phase_nx;
            r_ser        <= w_ser_nx;
            r_strobe     <= w_boundary;
            r_pend       <= w_pend_nx;
            r_drop       <= w_drop;
            r_state      <= w_state_nx;
            r_bit        <= w_bit_nx;
            r_held       <= w_held_nx;
            r_last_frame <= w_last_frame_nx;
            if (w_boundary) begin
                r_sym <= w_sym_nx;
            end
            if (w_accept) begin
                r_cmd <= i_cmd_data;
            end
            if (w_commit & w_frame_load) begin
                r_prev_state <= w_state;
                r_prev_bit   <= w_bit;
                r_prev_held  <= w_avail;
            end
        end
    end

endmodule

// File: tb/tb_ttc_frame_tx.sv
// tb/tb_ttc_frame_tx.sv - self-checking bench for ttc_frame_tx: vector table, corner sequences, random vs symbol-queue model
module tb_ttc_frame_tx;

    localparam int CW   = 16;
    localparam int MAXP = 3;
`ifdef TTC_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = CW + 1 + PAR;

    localparam logic [3:0] K_IDLE  = 4'b0000;
    localparam logic [3:0] K_TRIG  = 4'b1111;
    localparam logic [3:0] K_START = 4'b1001;
    localparam logic [3:0] K_D0    = 4'b1000;
    localparam logic [3:0] K_D1    = 4'b1100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bx_align = 1'b0;
    logic          trigger = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [CW-1:0] cmd_data = '0;
    logic          cmd_ready, ser_out, sym_strobe, busy, trig_dropped;

    always #3 clk = ~clk;

    ttc_frame_tx #(.CMD_WIDTH(CW), .MAX_PENDING(MAXP)) dut (
        .i_clk160      (clk),
        .i_rst         (rst),
        .i_bx_align    (bx_align),
        .i_trigger     (trigger),
        .i_cmd_valid   (cmd_valid),
        .i_cmd_data    (cmd_data),
        .o_cmd_ready   (cmd_ready),
        .o_ser_out     (ser_out),
        .o_sym_strobe  (sym_strobe),
        .o_busy        (busy),
        .o_trig_dropped(trig_dropped)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: BX-level view. A frame is a queue of symbols still to be sent.
    int         m_phase;
    int         m_pend;
    logic [3:0] m_line;
    bit         m_line_frame;
    bit         m_open;
    logic [3:0] m_q[$];

    bit   rec_on = 0;
    logic rec_ser[$];
    int   rec_busy;

    typedef struct {
        logic [CW-1:0] data;
        int            trig_bx;
        int            exp_len;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dsym(input logic b);
        return b ? K_D1 : K_D0;
    endfunction

    task automatic push_frame(input logic [CW-1:0] d);
        m_q.push_back(K_START);
        for (int i = CW - 1; i >= 0; i--) m_q.push_back(dsym(d[i]));
        if (PAR != 0) m_q.push_back(dsym(^d));
    endtask

    function automatic bit m_busy();
        return (m_q.size() > 0) || m_open;
    endfunction

    task automatic cyc(input logic trig, input logic valid, input logic [CW-1:0] data,
                       input logic align, input logic rst_in);
        bit bnd, tsel, dec, edrop, estb, busy_pre;
        rst = rst_in; trigger = trig; cmd_valid = valid; cmd_data = data; bx_align = align;
        edrop = 0; estb = 0;
        if (rst_in) begin
            m_phase = 0; m_pend = 0; m_line = K_IDLE; m_line_frame = 0; m_open = 0;
            m_q.delete();
        end else begin
            busy_pre = m_busy();
            bnd = (m_phase == 3) || align;
            if (valid && !busy_pre) push_frame(data);
            if (align && m_phase != 3 && m_line_frame) m_q.push_front(m_line);
            tsel = bnd && (m_pend > 0 || trig);
            dec  = bnd && tsel;
            if (trig) begin
                if (!dec) begin
                    if (m_pend < MAXP) m_pend++;
                    else edrop = 1;
                end
            end else if (dec) begin
                m_pend--;
            end
            if (bnd) begin
                if (tsel) begin
                    m_line = K_TRIG; m_line_frame = 0;
                end else if (m_q.size() > 0) begin
                    m_line = m_q.pop_front(); m_line_frame = 1; m_open = 1;
                end else begin
                    m_line = K_IDLE; m_line_frame = 0; m_open = 0;
                end
                m_phase = 0;
                estb = 1;
            end else begin
                m_phase++;
            end
        end
        @(posedge clk);
        #1;
        chk("ser_out", ser_out, m_line[3 - m_phase]);
        chk("sym_strobe", sym_strobe, estb);
        chk("busy", busy, m_busy());
        chk("cmd_ready", cmd_ready, (!rst_in && !m_busy()));
        chk("trig_dropped", trig_dropped, edrop);
        if (rec_on) begin
            rec_ser.push_back(ser_out);
            if (busy) rec_busy++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0);
    endtask

    // Idle until the next cycle is a decision cycle with nothing queued; accept then starts at once.
    task automatic wait_launch_slot();
        int guard = 0;
        while ((m_phase != 3 || m_busy() || m_pend != 0) && guard < 200) begin
            cyc(0, 0, '0, 0, 0);
            guard++;
        end
        chk("launch_wait_timeout", (guard < 200), 1);
    endtask

    initial begin
        logic [3:0] exp_syms[$];
        logic [3:0] got;
        int nsym;

        tbl[0] = '{16'hA5C3, -1, FLEN};
        tbl[1] = '{16'hA5C3,  7, FLEN + 1};
        tbl[2] = '{16'h0001, -1, FLEN};
        tbl[3] = '{16'hFFFF,  3, FLEN + 1};
        tbl[4] = '{16'h0000, -1, FLEN};

        cyc(0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, 1);
        chk("reset_ready_low", cmd_ready, 0);

        // idle line after reset
        idle(40);

        // single trigger at phase 1
        while (m_phase != 1) cyc(0, 0, '0, 0, 0);
        cyc(1, 0, '0, 0, 0);
        idle(12);

        // command frames from the vector table
        for (int v = 0; v < 5; v++) begin
            wait_launch_slot();
            rec_ser.delete();
            rec_busy = 0;
            rec_on = 1;
            cyc(0, 1, tbl[v].data, 0, 0);
            for (int k = 1; k < (tbl[v].exp_len + 1) * 4; k++)
                cyc((k == 4 * tbl[v].trig_bx + 1), 0, '0, 0, 0);
            rec_on = 0;
            chk($sformatf("vec%0d_busy_cycles", v), rec_busy, tbl[v].exp_len * 4);
            exp_syms.delete();
            exp_syms.push_back(K_START);
            for (int i = CW - 1; i >= 0; i--) exp_syms.push_back(dsym(tbl[v].data[i]));
            if (PAR != 0) exp_syms.push_back(dsym(^tbl[v].data));
            if (tbl[v].trig_bx >= 0) exp_syms.insert(tbl[v].trig_bx + 1, K_TRIG);
            exp_syms.push_back(K_IDLE);
            nsym = rec_ser.size() / 4;
            chk($sformatf("vec%0d_symbol_count", v), nsym, exp_syms.size());
            for (int j = 0; j < nsym && j < exp_syms.size(); j++) begin
                got = {rec_ser[4*j], rec_ser[4*j+1], rec_ser[4*j+2], rec_ser[4*j+3]};
                chk($sformatf("vec%0d_sym%0d", v, j), got, exp_syms[j]);
            end
        end

        // five consecutive trigger cycles starting at phase 0
        idle(8);
        while (m_phase != 3) cyc(0, 0, '0, 0, 0);
        cyc(0, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, '0, 0, 0);
        idle(24);
        chk("pend_drained", m_pend, 0);

        // bx_align truncating a data symbol mid-frame
        wait_launch_slot();
        cyc(0, 1, 16'h3C5A, 0, 0);
        idle(21);
        while (m_phase != 1) cyc(0, 0, '0, 0, 0);
        cyc(0, 0, '0, 1, 0);
        idle(FLEN * 4 + 12);

        // bx_align truncating the START symbol, with a trigger at that boundary
        wait_launch_slot();
        cyc(0, 1, 16'h8001, 0, 0);
        cyc(1, 0, '0, 1, 0);
        idle(FLEN * 4 + 12);

        // reset in the middle of a frame
        wait_launch_slot();
        cyc(0, 1, 16'hBEEF, 0, 0);
        idle(30);
        cyc(0, 0, '0, 0, 1);
        chk("midframe_rst_busy", busy, 0);
        cyc(0, 0, '0, 0, 0);
        chk("after_rst_ready", cmd_ready, 1);
        idle(8);

        // randomized traffic
        for (int i = 0; i < 4000; i++)
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0), CW'($urandom),
                ($urandom_range(0, 99) == 0), ($urandom_range(0, 999) == 0));
        idle(FLEN * 4 + 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
